// File: rtl/conv_pkg.sv
// Shared sizes, FSM states and configuration checks for the convolution window sequencer.
package conv_pkg;

   localparam int unsigned DIM_W    = 9;
   localparam int unsigned MAC_W    = 21;
   localparam int unsigned MAX_TAPS = 1023;
   localparam int unsigned PROD_W   = 2 * DIM_W;

   typedef enum logic [2:0] {
      IDLE, CLEAR, FEED, DRAIN, FLUSH, WAIT, EMIT, FINISH
   } state_t;

   typedef struct packed {
      logic [DIM_W-1:0] img_h;
      logic [DIM_W-1:0] img_w;
      logic [DIM_W-1:0] k_h;
      logic [DIM_W-1:0] k_w;
   } cfg_t;

   // True when the run cannot be sequenced: empty dims, kernel larger than image,
   // too many taps for the MAC counter, or an image that overflows the address space.
   function automatic logic cfg_reject(cfg_t c, int unsigned addr_w);
      logic [PROD_W-1:0] taps;
      logic [PROD_W-1:0] pixels;
      taps   = PROD_W'(c.k_h) * PROD_W'(c.k_w);
      pixels = PROD_W'(c.img_h) * PROD_W'(c.img_w);
      return (c.img_h == '0) || (c.img_w == '0) || (c.k_h == '0) || (c.k_w == '0)
          || (c.k_h > c.img_h) || (c.k_w > c.img_w)
          || (taps > PROD_W'(MAX_TAPS))
          || (33'(pixels) > (33'(1) << addr_w));
   endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Result stream: one saturated MAC result plus its feature-map address per transfer.
interface conv_window_sequencer_if
   import conv_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
);
   logic              valid;
   logic              ready;
   logic [MAC_W-1:0]  data;
   logic [ADDR_W-1:0] addr;

   modport master (output valid, data, addr, input ready);
   modport slave  (input valid, data, addr, output ready);
endinterface

// File: rtl/conv_addr_gen.sv
// Window/tap counters with running row bases; issues one tap address per step.
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              step,
   input  logic              advance,
   input  logic [DIM_W-1:0]  img_w,
   input  logic [DIM_W-1:0]  k_h,
   input  logic [DIM_W-1:0]  k_w,
   input  logic [DIM_W-1:0]  out_h,
   input  logic [DIM_W-1:0]  out_w,
   output logic              last_tap,
   output logic              last_window_c,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [ADDR_W-1:0] wgt_addr,
   output logic [ADDR_W-1:0] res_addr_c
);

   logic [DIM_W-1:0]  kx, ky, ox, oy;
   logic [ADDR_W-1:0] win_row_base, tap_row_base, wgt_row_base, res_row_base;
   logic              kx_wrap_c, ky_wrap_c, ox_wrap_c;

   assign kx_wrap_c     = (kx == k_w - DIM_W'(1));
   assign ky_wrap_c     = (ky == k_h - DIM_W'(1));
   assign ox_wrap_c     = (ox == out_w - DIM_W'(1));
   assign last_window_c = ox_wrap_c && (oy == out_h - DIM_W'(1));
   assign res_addr_c    = res_row_base + ADDR_W'(ox);

   // last_tap marks that the address currently presented is the final tap of the window.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         kx           <= '0;
         ky           <= '0;
         ox           <= '0;
         oy           <= '0;
         win_row_base <= '0;
         tap_row_base <= '0;
         wgt_row_base <= '0;
         res_row_base <= '0;
         pix_addr     <= '0;
         wgt_addr     <= '0;
         last_tap     <= 1'b0;
      end else begin
         if (step) begin
            pix_addr <= tap_row_base + ADDR_W'(ox) + ADDR_W'(kx);
            wgt_addr <= wgt_row_base + ADDR_W'(kx);
            last_tap <= kx_wrap_c && ky_wrap_c;
            if (!kx_wrap_c) begin
               kx <= kx + DIM_W'(1);
            end else begin
               kx <= '0;
               if (!ky_wrap_c) begin
                  ky           <= ky + DIM_W'(1);
                  tap_row_base <= tap_row_base + ADDR_W'(img_w);
                  wgt_row_base <= wgt_row_base + ADDR_W'(k_w);
               end else begin
                  ky           <= '0;
                  tap_row_base <= win_row_base;
                  wgt_row_base <= '0;
               end
            end
         end
         if (advance) begin
            if (!ox_wrap_c) begin
               ox <= ox + DIM_W'(1);
            end else begin
               ox           <= '0;
               oy           <= oy + DIM_W'(1);
               win_row_base <= win_row_base + ADDR_W'(img_w);
               tap_row_base <= win_row_base + ADDR_W'(img_w);
               res_row_base <= res_row_base + ADDR_W'(out_w);
            end
         end
      end
   end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every valid-mode output window, drives the MAC and streams captured results.
module conv_window_sequencer
   import conv_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DIM_W-1:0]          img_h,
   input  logic [DIM_W-1:0]          img_w,
   input  logic [DIM_W-1:0]          k_h,
   input  logic [DIM_W-1:0]          k_w,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [ADDR_W-1:0]         pix_addr,
   output logic [ADDR_W-1:0]         wgt_addr,
   output logic                      mac_en,
   output logic                      mac_clear,
   input  logic [MAC_W-1:0]          mac_out,
   input  logic                      mac_done,
   conv_window_sequencer_if.master   res
);

   state_t            state, state_d;
   logic              reject_q, reject_d;
   logic              accept_c, step_c, advance_c, latch_c;
   logic              last_tap, last_window_c;
   logic [DIM_W-1:0]  img_w_q, k_h_q, k_w_q, out_h_q, out_w_q;
   logic [ADDR_W-1:0] res_addr_c;
   logic              res_valid_q;
   logic [MAC_W-1:0]  res_data_q;
   logic [ADDR_W-1:0] res_addr_q;
   cfg_t              cfg_in_c;

   assign cfg_in_c  = '{img_h: img_h, img_w: img_w, k_h: k_h, k_w: k_w};
   assign res.valid = res_valid_q;
   assign res.data  = res_data_q;
   assign res.addr  = res_addr_q;

   conv_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk           (clk),
      .rst           (rst),
      .restart       (accept_c),
      .step          (step_c),
      .advance       (advance_c),
      .img_w         (img_w_q),
      .k_h           (k_h_q),
      .k_w           (k_w_q),
      .out_h         (out_h_q),
      .out_w         (out_w_q),
      .last_tap      (last_tap),
      .last_window_c (last_window_c),
      .pix_addr      (pix_addr),
      .wgt_addr      (wgt_addr),
      .res_addr_c    (res_addr_c)
   );

   // A rejected start parks one cycle in IDLE so done/err land two cycles after start.
   always_comb begin
      state_d   = state;
      reject_d  = 1'b0;
      accept_c  = 1'b0;
      step_c    = 1'b0;
      advance_c = 1'b0;
      latch_c   = 1'b0;
      case (state)
         IDLE: begin
            if (reject_q) begin
               state_d = FINISH;
            end else if (start) begin
               if (cfg_reject(cfg_in_c, ADDR_W)) begin
                  reject_d = 1'b1;
               end else begin
                  accept_c = 1'b1;
                  state_d  = CLEAR;
               end
            end
         end
         CLEAR: begin
            step_c  = 1'b1;
            state_d = FEED;
         end
         FEED: begin
            if (last_tap) state_d = DRAIN;
            else          step_c  = 1'b1;
         end
         DRAIN:  state_d = FLUSH;
         FLUSH:  state_d = WAIT;
         WAIT: begin
            if (mac_done) begin
               latch_c = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (res.ready) begin
               if (last_window_c) begin
                  state_d = FINISH;
               end else begin
                  advance_c = 1'b1;
                  state_d   = CLEAR;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state; mac_en trails each FEED cycle by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         reject_q    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         mac_en      <= 1'b0;
         mac_clear   <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_addr_q  <= '0;
         img_w_q     <= '0;
         k_h_q       <= '0;
         k_w_q       <= '0;
         out_h_q     <= '0;
         out_w_q     <= '0;
      end else begin
         state       <= state_d;
         reject_q    <= reject_d;
         busy        <= state_d inside {CLEAR, FEED, DRAIN, FLUSH, WAIT, EMIT};
         done        <= (state_d == FINISH);
         err         <= (state_d == FINISH) && reject_q;
         mac_en      <= (state == FEED) || (state_d == FLUSH);
         mac_clear   <= (state_d == CLEAR);
         res_valid_q <= (state_d == EMIT);
         if (accept_c) begin
            img_w_q <= img_w;
            k_h_q   <= k_h;
            k_w_q   <= k_w;
            out_h_q <= img_h - k_h + DIM_W'(1);
            out_w_q <= img_w - k_w + DIM_W'(1);
         end
         if (latch_c) begin
            res_data_q <= mac_out;
            res_addr_q <= res_addr_c;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench: behavioural memories and saturating MAC around the sequencer.
module tb_conv_window_sequencer;
   import conv_pkg::*;

   localparam int unsigned ADDR_W = 16;
   localparam longint      SAT_MAX = 1048575;

   logic              clk, rst, start;
   logic [DIM_W-1:0]  img_h, img_w, k_h, k_w;
   logic              busy, done, err, mac_en, mac_clear, mac_done;
   logic [ADDR_W-1:0] pix_addr, wgt_addr;
   logic [MAC_W-1:0]  mac_out;

   conv_window_sequencer_if #(.ADDR_W(ADDR_W)) res_if ();

   conv_window_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .img_h     (img_h),
      .img_w     (img_w),
      .k_h       (k_h),
      .k_w       (k_w),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .pix_addr  (pix_addr),
      .wgt_addr  (wgt_addr),
      .mac_en    (mac_en),
      .mac_clear (mac_clear),
      .mac_out   (mac_out),
      .mac_done  (mac_done),
      .res       (res_if)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int unsigned mac_n;
   logic        mon_clr;

   logic [7:0]  img_mem [1024];
   logic [7:0]  wgt_mem [1024];
   logic [7:0]  pix_q, wgt_q;
   longint      acc;
   int unsigned tap_cnt;

   int unsigned       rcnt, en_run, en_max;
   logic              en_seen, clr_seen;
   logic [MAC_W-1:0]  rdata [8];
   logic [ADDR_W-1:0] raddr [8];

   longint gold3 [4] = '{37, 47, 67, 77};
   longint pix0  [4] = '{0, 1, 3, 4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memories with one-cycle read latency.
   always @(posedge clk) begin
      pix_q <= img_mem[pix_addr[9:0]];
      wgt_q <= wgt_mem[wgt_addr[9:0]];
   end

   // MAC: first mac_n enables accumulate, the next one latches the saturated sum.
   always @(posedge clk) begin
      mac_done <= 1'b0;
      if (rst) begin
         acc     <= 0;
         tap_cnt <= 0;
         mac_out <= '0;
      end else if (mac_clear) begin
         acc     <= 0;
         tap_cnt <= 0;
      end else if (mac_en) begin
         if (tap_cnt < mac_n) begin
            acc     <= acc + longint'(pix_q) * longint'(wgt_q);
            tap_cnt <= tap_cnt + 1;
         end else begin
            mac_out  <= (acc > SAT_MAX) ? MAC_W'(SAT_MAX) : MAC_W'(acc);
            mac_done <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (mon_clr) begin
         rcnt     <= 0;
         en_run   <= 0;
         en_max   <= 0;
         en_seen  <= 1'b0;
         clr_seen <= 1'b0;
      end else begin
         if (res_if.valid && res_if.ready && rcnt < 8) begin
            rdata[rcnt[2:0]] <= res_if.data;
            raddr[rcnt[2:0]] <= res_if.addr;
            rcnt             <= rcnt + 1;
         end
         en_run <= mac_en ? en_run + 1 : 0;
         if (mac_en && (en_run + 1 > en_max)) en_max <= en_run + 1;
         if (mac_en)    en_seen  <= 1'b1;
         if (mac_clear) clr_seen <= 1'b1;
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int unsigned h, input int unsigned w,
                            input int unsigned kh, input int unsigned kw);
      img_h   = DIM_W'(h);
      img_w   = DIM_W'(w);
      k_h     = DIM_W'(kh);
      k_w     = DIM_W'(kw);
      mac_n   = kh * kw;
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      cyc     = 1;
   endtask

   task automatic wait_done(input int bound);
      while (!done && cyc < bound) begin
         tick();
         cyc++;
      end
      chk("done_reached", longint'(done), 1);
   endtask

   task automatic wait_valid(input int bound, input string tag);
      int n = 0;
      while (!res_if.valid && n < bound) begin
         tick();
         n++;
      end
      chk(tag, longint'(res_if.valid), 1);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      mon_clr      = 1'b0;
      res_if.ready = 1'b1;
      img_h = '0; img_w = '0; k_h = '0; k_w = '0;
      mac_n = 0;
      for (int i = 0; i < 1024; i++) begin
         img_mem[i] = 8'(i + 1);
         wgt_mem[i] = 8'(i + 1);
      end
      tick();
      tick();
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_err", longint'(err), 0);
      chk("rst_mac_en", longint'(mac_en), 0);
      chk("rst_mac_clear", longint'(mac_clear), 0);
      chk("rst_res_valid", longint'(res_if.valid), 0);
      chk("rst_pix_addr", longint'(pix_addr), 0);
      chk("rst_wgt_addr", longint'(wgt_addr), 0);
      chk("rst_res_data", longint'(res_if.data), 0);
      chk("rst_res_addr", longint'(res_if.addr), 0);
      rst = 1'b0;
      tick();

      // 3x3 image, 2x2 kernel: image 1..9, weights 1..4
      start_run(3, 3, 2, 2);
      chk("c1_busy", longint'(busy), 1);
      chk("c1_mac_clear", longint'(mac_clear), 1);
      chk("c1_mac_en", longint'(mac_en), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         cyc++;
         chk("w0_pix_addr", longint'(pix_addr), pix0[i]);
         chk("w0_wgt_addr", longint'(wgt_addr), longint'(i));
         chk("w0_mac_en", longint'(mac_en), (i == 0) ? 0 : 1);
      end
      wait_done(60);
      chk("run3_done_cycle", longint'(cyc), 37);
      chk("run3_err", longint'(err), 0);
      chk("run3_busy_finish", longint'(busy), 0);
      tick();
      chk("run3_count", longint'(rcnt), 4);
      for (int i = 0; i < 4; i++) begin
         chk("run3_addr", longint'(raddr[i]), longint'(i));
         chk("run3_data", longint'(rdata[i]), gold3[i]);
      end
      tick();

      // Same run with back-pressure on result 1 and a start pulse while busy
      res_if.ready = 1'b0;
      start_run(3, 3, 2, 2);
      wait_valid(50, "stall_r0_valid");
      chk("stall_r0_data", longint'(res_if.data), 37);
      res_if.ready = 1'b1;
      tick();
      res_if.ready = 1'b0;
      start = 1'b1;
      img_w = DIM_W'(7);
      tick();
      start = 1'b0;
      img_w = DIM_W'(3);
      wait_valid(50, "stall_r1_valid");
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", longint'(res_if.valid), 1);
         chk("stall_data", longint'(res_if.data), 47);
         chk("stall_addr", longint'(res_if.addr), 1);
         chk("stall_mac_en", longint'(mac_en), 0);
         tick();
      end
      res_if.ready = 1'b1;
      cyc = 0;
      wait_done(100);
      tick();
      chk("stall_count", longint'(rcnt), 4);
      for (int i = 0; i < 4; i++) begin
         chk("stall_res_addr", longint'(raddr[i]), longint'(i));
         chk("stall_res_data", longint'(rdata[i]), gold3[i]);
      end
      tick();

      // Reset in the middle of FEED
      start_run(3, 3, 2, 2);
      tick();
      tick();
      chk("midfeed_mac_en", longint'(mac_en), 1);
      rst = 1'b1;
      tick();
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_mac_en", longint'(mac_en), 0);
      chk("midrst_mac_clear", longint'(mac_clear), 0);
      chk("midrst_pix_addr", longint'(pix_addr), 0);
      chk("midrst_wgt_addr", longint'(wgt_addr), 0);
      chk("midrst_res_valid", longint'(res_if.valid), 0);
      chk("midrst_done", longint'(done), 0);
      rst = 1'b0;
      tick();

      // 4x4 image, 4x4 kernel: pixels 0..15, weights all 1 -> 120
      for (int i = 0; i < 16; i++) begin
         img_mem[i] = 8'(i);
         wgt_mem[i] = 8'd1;
      end
      start_run(4, 4, 4, 4);
      wait_done(100);
      chk("k4_done_cycle", longint'(cyc), 22);
      tick();
      chk("k4_count", longint'(rcnt), 1);
      chk("k4_addr", longint'(raddr[0]), 0);
      chk("k4_data", longint'(rdata[0]), 120);
      chk("k4_en_run", longint'(en_max), 17);
      tick();

      // Saturation: 25 taps of 255*255
      for (int i = 0; i < 1024; i++) begin
         img_mem[i] = 8'hff;
         wgt_mem[i] = 8'hff;
      end
      start_run(5, 5, 5, 5);
      wait_done(100);
      chk("sat_done_cycle", longint'(cyc), 31);
      chk("sat_err", longint'(err), 0);
      tick();
      chk("sat_data", longint'(rdata[0]), SAT_MAX);
      tick();

      // Rejects: kernel wider than image, then too many taps
      start_run(4, 4, 1, 5);
      chk("rej_w_done_c1", longint'(done), 0);
      chk("rej_w_busy_c1", longint'(busy), 0);
      tick();
      chk("rej_w_done_c2", longint'(done), 1);
      chk("rej_w_err_c2", longint'(err), 1);
      tick();
      tick();
      chk("rej_w_no_en", longint'(en_seen), 0);
      chk("rej_w_no_clear", longint'(clr_seen), 0);

      start_run(40, 40, 33, 33);
      tick();
      chk("rej_n_done_c2", longint'(done), 1);
      chk("rej_n_err_c2", longint'(err), 1);
      tick();
      tick();
      chk("rej_n_no_en", longint'(en_seen), 0);
      chk("rej_n_no_clear", longint'(clr_seen), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Sequences the `convolution` MAC over a stored image to produce one valid-mode (stride 1, no padding) feature map. For every output position it walks the kernel window and issues pixel and weight read addresses to single-port ROM/RAMs with 1-cycle read latency. It drives the MAC's `en`/`clear` and captures each saturated 21-bit result. Results go out on a valid/ready port together with their feature-map address.

## Interface
- `ADDR_W`, 16: width of pixel, weight and result addresses.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `img_h`, `img_w`  in  9 each  image dimensions; latched at start.
- `k_h`, `k_w`  in  9 each  kernel dimensions; latched at start.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  1-cycle pulse at end of run.
- `err`  out  1  valid with done; config rejected.
- `pix_addr`  out  ADDR_W  image read address.
- `wgt_addr`  out  ADDR_W  kernel read address.
- `mac_en`  out  1  to MAC `en`.
- `mac_clear`  out  1  to MAC `clear`.
- `mac_out`  in  21  MAC `out`.
- `mac_done`  in  1  MAC `done`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  21  captured MAC result.
- `res_addr`  out  ADDR_W  `oy*out_w + ox`.

## Operation
- Output size: `out_h = img_h-k_h+1`, `out_w = img_w-k_w+1`. Window taps: `N = k_h*k_w`.
- Reject when any dimension is 0, `k_h>img_h`, `k_w>img_w`, `N>1023` (MAC counter limit), or `img_h*img_w > 2^ADDR_W`.
  - On reject: go IDLE→FINISH; `done=1`, `err=1`; no `mac_en`/`mac_clear` issued.
- States:
  - IDLE→CLEAR on start (valid config).
  - CLEAR (1 cycle, `mac_clear=1`)→FEED.
  - FEED (N cycles; one tap address per cycle, kx fastest then ky)→DRAIN.
  - DRAIN (1)→FLUSH (1)→WAIT.
  - WAIT: when `mac_done=1`, latch `mac_out` into `res_data`, go EMIT. Otherwise stay.
  - EMIT: `res_valid=1`. On `res_valid&&res_ready`, advance ox (then oy) and go to CLEAR, or to FINISH after the last window.
  - FINISH (1 cycle, `done=1`)→IDLE.
- Addresses: `pix_addr = (oy+ky)*img_w + (ox+kx)`, `wgt_addr = ky*k_w + kx`. Both are built from running adders (row-base accumulators), not multipliers.
- `mac_en` is high in the cycle after each FEED cycle (covers FEED+1..DRAIN) and in FLUSH. That gives exactly N+1 consecutive enable cycles per window; the final enable makes the MAC latch and assert done.
- `start` while busy is ignored; run config is held in registers.
- `rst` in any state: immediately IDLE; counters cleared; in-flight result discarded.
- `res_data`/`res_addr` stay stable while `res_valid && !res_ready`. No MAC activity during EMIT stall.

## Timing
- Reset values: `busy`, `done`, `err`, `mac_en`, `mac_clear`, `res_valid` = 0; `pix_addr`, `wgt_addr`, `res_data`, `res_addr` = 0.
- Cycle 0 = `start` sampled. CLEAR is cycle 1. The first tap address is in cycle 2, and its data meets `mac_en` in cycle 3.
- Per window with `res_ready=1`: N+5 cycles (CLEAR + N + DRAIN + FLUSH + WAIT + EMIT). `mac_done` is seen in WAIT, the cycle after FLUSH.
- Total run, no stalls: `out_h*out_w*(N+5)` + 1 (FINISH). `busy` falls in the FINISH cycle.
- `res_valid` may not depend combinationally on `res_ready`.

## Structure
- Package `conv_pkg`:
  - state enum (IDLE, CLEAR, FEED, DRAIN, FLUSH, WAIT, EMIT, FINISH);
  - `DIM_W=9`, `MAC_W=21`, `MAX_TAPS=1023`.
- Sub-module `conv_addr_gen`: nested kx/ky/ox/oy counters, row-base accumulators, `last_tap`/`last_window` flags, and address outputs. It has step/restart inputs driven by the FSM.

## Test plan
- 3x3 image, 2x2 kernel, `res_ready=1`, behavioural MAC plus memories:
  - window 0 pix 0,1,3,4 and wgt 0,1,2,3;
  - 4 results at `res_addr` 0..3 match golden;
  - `done` at cycle 37; `err=0`.
- Same run with `res_ready` low for 5 cycles at result 1: `res_valid`, `res_data`, `res_addr` held; `mac_en`=0 throughout stall; results unchanged.
- 4x4 image, 4x4 kernel: exactly one result at `res_addr=0`; `mac_en` high 17 consecutive cycles.
- Reject cases:
  - `k_w=5`, `img_w=4`: `done=1`, `err=1` at cycle 2; `mac_en`/`mac_clear` never asserted.
  - `k_h=k_w=33` (N=1089): same response.
- Saturation: all pixels and weights 255, 5x5 kernel on 5x5 image: `res_data=1048575`.
- `rst` mid-FEED: next cycle all outputs at reset values. `start` pulsed while busy: no effect on addresses or result count.
